io_regfile: RTL and testbench

Parametrised processor register file with memory-mapped I/O: the next generation of the 32×32 two-read/one-write register file that feeds the processor core. It adds synchronised and debounced button registers with sticky press flags, a packed switch register, externally sampled input registers and a packed output bus for motor/servo control registers. All mappings and the debounce window are parameters, so the same block serves every board build.

---
 rtl/io_regfile.sv | 150 +++++++++++++++
 tb/tb_io_regfile.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/io_regfile.sv
// rtl/io_regfile.sv - register file with debounced buttons, switches, sampled inputs and exported outputs
// Optional REGFILE_BYPASS_EN: same-cycle write-through on general registers.
module io_regfile #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int BTN_BASE        = 1,
  parameter int BTN_COUNT       = 5,
  parameter int SW_ADDR         = 20,
  parameter int SW_COUNT        = 16,
  parameter int EXT_BASE        = 8,
  parameter int EXT_COUNT       = 2,
  parameter int OUT_BASE        = 11,
  parameter int OUT_COUNT       = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                            clock,
  input  logic                            ctrl_reset,
  input  logic                            ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]           ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]           data_writeReg,
  input  logic [ADDR_WIDTH-1:0]           ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]           ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]           data_readRegA,
  output logic [DATA_WIDTH-1:0]           data_readRegB,
  input  logic [BTN_COUNT-1:0]            btn,
  input  logic [SW_COUNT-1:0]             switch,
  input  logic [EXT_COUNT*DATA_WIDTH-1:0] ext_in,
  output logic [OUT_COUNT*DATA_WIDTH-1:0] out_regs
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, COUNTING} dbState_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] extReg [EXT_COUNT];
  logic [SW_COUNT-1:0]   swS1, swS2;
  logic [BTN_COUNT-1:0]  btnS1, btnS2, btnLevel, btnSticky;

  // Only unmapped nonzero indices hold CPU-written storage.
  function automatic logic isGeneral(input logic [ADDR_WIDTH-1:0] idx);
    int i;
    i = int'(idx);
    return (i != 0) && !(i >= BTN_BASE && i < BTN_BASE + BTN_COUNT) &&
           (i != SW_ADDR) && !(i >= EXT_BASE && i < EXT_BASE + EXT_COUNT);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] readReg(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = regs[idx];
    if (int'(idx) == 0) val = '0;
    if (int'(idx) == SW_ADDR) val = DATA_WIDTH'(swS2);
    for (int b = 0; b < BTN_COUNT; b++)
      if (int'(idx) == BTN_BASE + b) val = {{(DATA_WIDTH-2){1'b0}}, btnSticky[b], btnLevel[b]};
    for (int e = 0; e < EXT_COUNT; e++)
      if (int'(idx) == EXT_BASE + e) val = extReg[e];
    return val;
  endfunction

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      for (int e = 0; e < EXT_COUNT; e++) extReg[e] <= '0;
      swS1  <= '0;
      swS2  <= '0;
      btnS1 <= '0;
      btnS2 <= '0;
    end else begin
      if (ctrl_writeEnable && isGeneral(ctrl_writeReg)) regs[ctrl_writeReg] <= data_writeReg;
      for (int e = 0; e < EXT_COUNT; e++) extReg[e] <= ext_in[e*DATA_WIDTH +: DATA_WIDTH];
      swS1  <= switch;
      swS2  <= swS1;
      btnS1 <= btn;
      btnS2 <= btnS1;
    end
  end

  for (genvar b = 0; b < BTN_COUNT; b++) begin : g_btn
    dbState_t         state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic             level, nextLevel, sticky, nextSticky, accept, clearReq;

    assign clearReq     = ctrl_writeEnable && (int'(ctrl_writeReg) == BTN_BASE + b) && data_writeReg[1];
    assign btnLevel[b]  = level;
    assign btnSticky[b] = sticky;

    always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
        state  <= STABLE;
        cnt    <= '0;
        level  <= 1'b0;
        sticky <= 1'b0;
      end else begin
        state  <= nextState;
        cnt    <= nextCnt;
        level  <= nextLevel;
        sticky <= nextSticky;
      end
    end

    always_comb begin
      nextState = state;
      accept    = 1'b0;
      unique case (state)
        STABLE:
          if (btnS2[b] != level) begin
            if (DEBOUNCE_CYCLES == 1) accept = 1'b1;
            else nextState = COUNTING;
          end
        COUNTING:
          if (btnS2[b] == level) nextState = STABLE;
          else if (cnt == DB_LAST) begin
            accept    = 1'b1;
            nextState = STABLE;
          end
        default: nextState = STABLE;
      endcase
    end

    // A press accepted in the same cycle as a W1C keeps the flag set.
    always_comb begin
      nextCnt    = '0;
      nextLevel  = level;
      nextSticky = sticky & ~clearReq;
      if (accept) begin
        nextLevel = btnS2[b];
        if (btnS2[b]) nextSticky = 1'b1;
      end else if (nextState == COUNTING) begin
        nextCnt = cnt + CNT_W'(1);
      end
    end
  end

  for (genvar o = 0; o < OUT_COUNT; o++) begin : g_out
    assign out_regs[o*DATA_WIDTH +: DATA_WIDTH] = regs[OUT_BASE + o];
  end

`ifdef REGFILE_BYPASS_EN
  logic bypassOk;
  assign bypassOk      = ctrl_writeEnable && isGeneral(ctrl_writeReg);
  assign data_readRegA = (bypassOk && ctrl_readRegA == ctrl_writeReg) ? data_writeReg : readReg(ctrl_readRegA);
  assign data_readRegB = (bypassOk && ctrl_readRegB == ctrl_writeReg) ? data_writeReg : readReg(ctrl_readRegB);
`else
  assign data_readRegA = readReg(ctrl_readRegA);
  assign data_readRegB = readReg(ctrl_readRegB);
`endif

endmodule

// File: tb/tb_io_regfile.sv
// tb/tb_io_regfile.sv - directed self-checking bench for io_regfile
module tb_io_regfile;
  logic         clock = 1'b0;
  logic         ctrl_reset;
  logic         ctrl_writeEnable;
  logic [4:0]   ctrl_writeReg;
  logic [31:0]  data_writeReg;
  logic [4:0]   ctrl_readRegA, ctrl_readRegB;
  logic [31:0]  data_readRegA, data_readRegB;
  logic [4:0]   btn;
  logic [15:0]  switch;
  logic [63:0]  ext_in;
  logic [159:0] out_regs;

  int errors = 0;
  int checks = 0;

  io_regfile dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .btn(btn), .switch(switch), .ext_in(ext_in), .out_regs(out_regs)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    ctrl_readRegA = idx;
    ctrl_readRegB = idx;
    #1;
    check({tag, "_A"}, 160'(data_readRegA), 160'(exp));
    check({tag, "_B"}, 160'(data_readRegB), 160'(exp));
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = idx;
    data_writeReg    = val;
    tick();
    ctrl_writeEnable = 1'b0;
  endtask

  initial begin
    ctrl_reset = 1'b0; ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7;
    data_writeReg = 32'hDEADBEEF; ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    btn = '0; switch = '0; ext_in = '0;
    tick(2);
    rd("reset_r7", 5'd7, 32'h0);
    check("reset_out", out_regs, 160'h0);
    rd("reset_r1", 5'd1, 32'h0);
    ctrl_writeEnable = 1'b0;
    ctrl_reset = 1'b1;

    wr(5'd11, 32'h64);
    wr(5'd15, 32'h5A);
    check("out_slice0", 160'(out_regs[31:0]), 160'h64);
    check("out_slice4", 160'(out_regs[159:128]), 160'h5A);
    wr(5'd0, 32'hFFFFFFFF);
    rd("r0_write", 5'd0, 32'h0);
    wr(5'd7, 32'hDEADBEEF);
    rd("r7_write", 5'd7, 32'hDEADBEEF);

    btn[0] = 1'b1;
    tick(5);
    rd("db_edge5", 5'd1, 32'h0);
    tick(1);
    rd("db_edge6", 5'd1, 32'h3);
    btn[0] = 1'b0;
    tick(6);
    rd("db_release", 5'd1, 32'h2);
    wr(5'd1, 32'h2);
    rd("w1c_clear", 5'd1, 32'h0);

    btn[0] = 1'b1;
    tick(2);
    btn[0] = 1'b0;
    tick(8);
    rd("glitch", 5'd1, 32'h0);

    btn[0] = 1'b1;
    tick(5);
    rd("coinc_pre", 5'd1, 32'h0);
    wr(5'd1, 32'h2);
    rd("coinc_set_wins", 5'd1, 32'h3);
    wr(5'd1, 32'hFFFF_FFFD);
    rd("btn_other_bits", 5'd1, 32'h3);

    switch = 16'h8001;
    tick(1);
    rd("sw_edge1", 5'd20, 32'h0);
    tick(1);
    rd("sw_edge2", 5'd20, 32'h00008001);
    wr(5'd20, 32'h0);
    rd("sw_write_ign", 5'd20, 32'h00008001);

    ext_in = {32'h123, 32'h55};
    tick(1);
    rd("ext_r9", 5'd9, 32'h123);
    rd("ext_r8", 5'd8, 32'h55);
    wr(5'd9, 32'h0);
    rd("ext_write_ign", 5'd9, 32'h123);

    wr(5'd25, 32'h1111);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd25; data_writeReg = 32'hCAFE;
    ctrl_readRegA = 5'd25; ctrl_readRegB = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same", 160'(data_readRegA), 160'hCAFE);
`else
    check("bypass_same", 160'(data_readRegA), 160'h1111);
`endif
    check("bypass_portB", 160'(data_readRegB), 160'h0);
    tick(1);
    ctrl_writeEnable = 1'b0;
    rd("bypass_next", 5'd25, 32'hCAFE);

    btn[1] = 1'b1;
    tick(4);
    ctrl_reset = 1'b0;
    tick(1);
    ctrl_reset = 1'b1;
    rd("mid_reset_r2", 5'd2, 32'h0);
    rd("mid_reset_r1", 5'd1, 32'h0);
    rd("mid_reset_r25", 5'd25, 32'h0);
    check("mid_reset_out", out_regs, 160'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
